// File: rtl/haar_cascade_pkg.sv
// haar_cascade_pkg: FSM states and cascade memory-layout helpers for the parameter sequencer.
package haar_cascade_pkg;
   typedef enum logic [1:0] {IDLE, STREAM, WAIT_RESULT, DONE} state_t;
   function automatic int stage_count(input logic [127:0] counts, input int s);
      return int'(counts[s*8 +: 8]);
   endfunction
   function automatic int stage_size(input logic [127:0] counts, input int s, input int np, input int nt);
      return stage_count(counts, s) * np + nt;
   endfunction
   function automatic int stage_base(input logic [127:0] counts, input int s, input int np, input int nt);
      int b = 0;
      for (int i = 0; i < s; i++) b += stage_size(counts, i, np, nt);
      return b;
   endfunction
endpackage

// File: rtl/haar_cascade_param_sequencer_rom.sv
// cascade_param_rom: single-port synchronous cascade ROM, 1-cycle latency, output held while rden is low.
// Contents are an address-derived image; an empty image name gives a blank ROM.
module cascade_param_rom #(
   parameter int AW = 14,
   parameter int DW = 12,
   parameter FILE_CASCADE_MEM = "cascade.mif"
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          rden,
   input  logic [AW-1:0] addr,
   output logic [DW-1:0] q
);
   localparam bit BLANK = FILE_CASCADE_MEM == "";
   always_ff @(posedge clk)
      if (rst) q <= '0;
      else if (rden) q <= BLANK ? '0 : DW'(addr * AW'(7) + AW'(13));
endmodule

// File: rtl/haar_cascade_param_sequencer.sv
// haar_cascade_param_sequencer: streams each cascade stage's parameters and thresholds, exits on first failed stage.
// Optional HAAR_SEQ_PERF_CNT_EN adds stall and verdict counters.
module haar_cascade_param_sequencer
   import haar_cascade_pkg::*;
#(
   parameter int NUM_STAGES = 8,
   parameter int ADDR_WIDTH = 12,
   parameter int ROM_ADDR_WIDTH = 14,
   parameter int DATA_WIDTH_12 = 12,
   parameter int NUM_PARAM_PER_CLASSIFIER = 18,
   parameter int NUM_STAGE_THRESHOLD = 3,
   parameter logic [NUM_STAGES*8-1:0] CLASSIFIER_COUNTS = {8'd99, 8'd91, 8'd83, 8'd72, 8'd62, 8'd53, 8'd52, 8'd32},
   parameter FILE_CASCADE_MEM = "cascade.mif"
) (
   input  logic                     clk_fpga,
   input  logic                     reset_fpga,
   input  logic                     i_start,
   input  logic                     i_abort,
   output logic                     o_valid,
   input  logic                     i_ready,
   output logic [DATA_WIDTH_12-1:0] o_data,
   output logic [ADDR_WIDTH-1:0]    o_stage_index,
   output logic [ADDR_WIDTH-1:0]    o_classifier_index,
   output logic [ADDR_WIDTH-1:0]    o_param_index,
   output logic                     o_is_threshold,
   output logic                     o_last_word,
   input  logic                     i_result_valid,
   input  logic                     i_result_pass,
   output logic                     o_busy,
   output logic                     o_done,
   output logic                     o_face_detected,
   output logic [ADDR_WIDTH-1:0]    o_fail_stage
`ifdef HAAR_SEQ_PERF_CNT_EN
  ,output logic [31:0]              o_stall_cycles,
   output logic [ADDR_WIDTH-1:0]    o_stages_evaluated
`endif
);
   localparam int NP = NUM_PARAM_PER_CLASSIFIER;
   localparam int NT = NUM_STAGE_THRESHOLD;
   localparam int SW = NUM_STAGES > 1 ? $clog2(NUM_STAGES) : 1;
   localparam int LW = ROM_ADDR_WIDTH + 1;
   localparam logic [127:0] CNT = 128'(CLASSIFIER_COUNTS);
   localparam int TOTAL = stage_base(CNT, NUM_STAGES, NP, NT);

   if (TOTAL > 2**ROM_ADDR_WIDTH) begin : g_rom_overflow
      $error("cascade image does not fit the ROM address space");
   end

   logic [7:0]                cnt_tbl  [2**SW];
   logic [LW-1:0]             size_tbl [2**SW];
   logic [ROM_ADDR_WIDTH-1:0] base_tbl [2**SW];
   for (genvar s = 0; s < 2**SW; s++) begin : g_tbl
      assign cnt_tbl[s]  = 8'(stage_count(CNT, s));
      assign size_tbl[s] = LW'(stage_size(CNT, s, NP, NT));
      assign base_tbl[s] = ROM_ADDR_WIDTH'(stage_base(CNT, s, NP, NT));
   end

   state_t                    state;
   logic [SW-1:0]             stg, ns;
   logic [ROM_ADDR_WIDTH-1:0] addr;
   logic [LW-1:0]             left;
   logic [ADDR_WIDTH-1:0]     nxt_cls, nxt_param;
   logic                      nxt_thr, accept, rden, start_ok, verdict, last_stage, load;

   assign accept     = o_valid && i_ready;
   assign rden       = state == STREAM && !i_abort && (!o_valid || i_ready) && left != '0;
   assign start_ok   = state == IDLE && i_start && !i_abort;
   assign verdict    = state == WAIT_RESULT && i_result_valid && !i_abort;
   assign last_stage = stg == SW'(NUM_STAGES - 1);
   assign load       = start_ok || (verdict && i_result_pass && !last_stage);
   assign ns         = start_ok ? '0 : stg + SW'(1);
   assign o_busy        = state != IDLE;
   assign o_stage_index = ADDR_WIDTH'(stg);

   cascade_param_rom #(.AW(ROM_ADDR_WIDTH), .DW(DATA_WIDTH_12), .FILE_CASCADE_MEM(FILE_CASCADE_MEM)) u_rom (
      .clk(clk_fpga), .rst(reset_fpga), .rden(rden), .addr(addr), .q(o_data)
   );

   always_ff @(posedge clk_fpga)
      if (reset_fpga) begin
         state <= IDLE;
         stg <= '0;
         addr <= '0;
         left <= '0;
         nxt_cls <= '0;
         nxt_param <= '0;
         nxt_thr <= 1'b0;
         o_valid <= 1'b0;
         o_done <= 1'b0;
         o_face_detected <= 1'b0;
         o_fail_stage <= '0;
         o_classifier_index <= '0;
         o_param_index <= '0;
         o_is_threshold <= 1'b0;
         o_last_word <= 1'b0;
      end else begin
         o_done <= 1'b0;
         if (load) begin
            stg <= ns;
            addr <= base_tbl[ns];
            left <= size_tbl[ns];
            nxt_cls <= '0;
            nxt_param <= '0;
            nxt_thr <= cnt_tbl[ns] == 8'd0;
         end
         // index outputs are loaded together with the word they describe
         if (rden) begin
            o_valid <= 1'b1;
            addr <= addr + ROM_ADDR_WIDTH'(1);
            left <= left - LW'(1);
            o_classifier_index <= nxt_cls;
            o_param_index <= nxt_param;
            o_is_threshold <= nxt_thr;
            o_last_word <= left == LW'(1);
            if (!nxt_thr && nxt_param == ADDR_WIDTH'(NP - 1)) begin
               nxt_param <= '0;
               nxt_cls <= nxt_cls + ADDR_WIDTH'(1);
               nxt_thr <= nxt_cls + ADDR_WIDTH'(1) == ADDR_WIDTH'(cnt_tbl[stg]);
            end else nxt_param <= nxt_param + ADDR_WIDTH'(1);
         end else if (accept) o_valid <= 1'b0;
         case (state)
            IDLE: if (start_ok) begin
               state <= STREAM;
               o_face_detected <= 1'b0;
               o_fail_stage <= '0;
            end
            STREAM: if (i_abort) begin
               state <= IDLE;
               o_valid <= 1'b0;
            end else if (accept && o_last_word) state <= WAIT_RESULT;
            WAIT_RESULT: if (i_abort) state <= IDLE;
            else if (verdict) begin
               state <= load ? STREAM : DONE;
               if (!load) begin
                  o_done <= 1'b1;
                  o_face_detected <= i_result_pass;
                  o_fail_stage <= i_result_pass ? '0 : ADDR_WIDTH'(stg);
               end
            end
            default: state <= IDLE;
         endcase
      end

`ifdef HAAR_SEQ_PERF_CNT_EN
   always_ff @(posedge clk_fpga)
      if (reset_fpga || start_ok) begin
         o_stall_cycles <= '0;
         o_stages_evaluated <= '0;
      end else begin
         if (o_valid && !i_ready && !(&o_stall_cycles)) o_stall_cycles <= o_stall_cycles + 32'd1;
         if (verdict && !(&o_stages_evaluated)) o_stages_evaluated <= o_stages_evaluated + ADDR_WIDTH'(1);
      end
`endif
endmodule
